alu_op_sequencer: RTL and testbench
===================================

# alu_op_sequencer

Hardwired control unit for the 32-bit bus-based datapath: it steps the datapath through instruction fetch and the execute steps of three-register ALU instructions by driving the datapath's out/in enables, ALU opcode and register-select vectors. It sits between memory and the CPU datapath and replaces the step-by-step control a testbench would otherwise apply by hand. It decodes the instruction register fields Ra/Rb/Rc and opcode, and it waits on a memory acknowledge during the fetch read.

## Interface
- TIMEOUT, 15: maximum cycles T1 waits for Mem_ack before aborting
- Clock  in  1  single system clock, rising edge
- Clear  in  1  asynchronous, active-low reset
- Run  in  1  level; start/continue instruction execution
- IR  in  32  datapath IR contents. Fields: opcode = IR[31:27], Ra = IR[26:23], Rb = IR[22:19], Rc = IR[18:15]
- Mem_ack  in  1  memory read data valid on Mdatain
- PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin  out  1 each  datapath enables
- ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin  out  1 each  Z/LO/HI enables
- Rin  out  16  one-hot register write enable (R0..R15)
- Rout  out  16  one-hot register bus drive
- ALU_op  out  5  ALU operation code
- Busy  out  1  high in every state except IDLE
- Done  out  1  one-cycle pulse on the final step of an instruction
- Illegal  out  1  one-cycle pulse when an undecoded opcode is seen in T3
- Bus_err  out  1  one-cycle pulse on a T1 timeout

## Operation
- States: IDLE, T0, T1, T2, T3, T4, T5, T6. Outputs are Moore-decoded from the state register and the IR inputs; all are 0 in IDLE.
- IDLE: if Run = 1, go to T0.
- T0: PCout, MARin, IncPC. Next state is T1.
- T1: Read and MDRin held high.
  - Mem_ack = 1: go to T2.
  - Otherwise the wait counter increments. Reaching TIMEOUT without an ack: pulse Bus_err, go to IDLE.
- T2: MDRout, IRin. Next state is T3.
- T3: Rout[Rb], Yin.
  - If the opcode is illegal: pulse Illegal, drive Rout = 0 and Yin = 0, go to IDLE.
  - Otherwise go to T4.
- T4: Rout[Rc], ALU_op = opcode, ZLowIn. For MUL/DIV, ZHighIn is also asserted. Next state is T5.
- T5:
  - Non-MUL/DIV opcodes: Zlowout, Rin[Ra], Done. Then T0 if Run = 1, else IDLE.
  - MUL/DIV: Zlowout, LOin. Next state is T6.
- T6 (MUL/DIV only): ZHighout, HIin, Done. Then T0 if Run = 1, else IDLE.
- Legal opcodes:
  - ADD 00011, SUB 00100, SHR 00101, SHL 00110, ROR 00111, ROL 01000, AND 01001, OR 01010
  - MUL 01111 and DIV 10000, only when MULDIV_EN is defined
- Rin and Rout are decoded one-hot from the 4-bit fields. A field value of 0 selects R0.
- At most one bus driver (PCout, MDRout, any Rout bit, Zlowout, ZHighout) is high in any cycle.

## Timing
- Reset: Clear low forces state IDLE, clears the wait counter, and drives every output to 0 immediately (asynchronous). This holds in any state, including mid-T1.
- Latency from leaving IDLE to Done:
  - ALU op: 6 cycles plus T1 wait cycles
  - MUL/DIV: 7 cycles plus T1 wait cycles
- Mem_ack sampled on the rising edge that ends a T1 cycle. Ack arriving with zero wait gives a single T1 cycle.
- Ack and timeout on the same edge: the ack wins and the FSM goes to T2; Bus_err does not pulse.
- The wait counter resets on every entry to T1 and saturates at TIMEOUT.
- IR must be stable from the cycle after T2 through the last step. The sequencer does not latch IR.
- Run dropping mid-instruction does not abort; it is checked only in IDLE and on the Done cycle.
- Back-to-back instructions: Done cycle is followed directly by T0, with no IDLE bubble.

## Configuration
- MULDIV_EN defined:
  - MUL and DIV are legal.
  - T4 asserts ZHighIn; T5 writes LO, T6 writes HI.
- MULDIV_EN undefined:
  - Opcodes 01111 and 10000 pulse Illegal in T3.
  - State T6 and the HIin/LOin/ZHighIn/ZHighout drives are removed; those outputs are tied 0.

## Test plan
- AND, immediate ack: Clear released, Run = 1, Mem_ack = 1, IR = 32'h4A920000.
  - Sequence T0..T5.
  - T3: Rout = 16'h0004, Yin.
  - T4: Rout = 16'h0010, ALU_op = 01001, ZLowIn.
  - T5: Rin = 16'h0020, Zlowout, Done.
- Memory wait: Mem_ack delayed 3 cycles. T1 lasts 4 cycles with Read/MDRin held high; Done arrives 9 cycles after leaving IDLE.
- Timeout: Mem_ack never asserted, TIMEOUT = 15. Bus_err pulses once after 15 T1 cycles; FSM returns to IDLE; no IRin is asserted.
- Illegal opcode: IR = 32'hF8000000. Illegal pulses in T3; Yin, Rout and ZLowIn are never asserted; FSM goes to IDLE.
- MUL with MULDIV_EN defined: IR opcode 01111. T4 asserts ZLowIn and ZHighIn; T5 asserts LOin; T6 asserts HIin and Done. Without MULDIV_EN the same IR pulses Illegal.
- Reset mid-T1: Clear pulled low during the T1 wait. All outputs go to 0 within the same cycle; after Clear is released with Run = 1, the next cycle is T0.

Source files
------------

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer: hardwired control for the 32-bit bus datapath.
// It steps the datapath through an instruction fetch (T0..T2) and then the
// execute steps of a three-register ALU instruction (T3..T5, plus T6 for
// MUL/DIV).
// Optional feature: define MULDIV_EN to make MUL (01111) and DIV (10000)
// legal. When it is defined, T4 loads ZHigh, T5 writes LO and T6 writes HI.
// When it is left undefined, those two opcodes are illegal and
// ZHighIn/ZHighout/LOin/HIin stay 0.
// Outputs are decoded from the state register, the IR fields and Mem_ack.
// They are not registered: IR is only loaded at the end of T2, so T3 must
// see the new IR straight away.
module alu_op_sequencer #(
    parameter int TIMEOUT = 15
) (
    input  logic        Clock,
    input  logic        Clear,
    input  logic        Run,
    input  logic [31:0] IR,
    input  logic        Mem_ack,
    output logic        PCout,
    output logic        MARin,
    output logic        IncPC,
    output logic        Read,
    output logic        MDRin,
    output logic        MDRout,
    output logic        IRin,
    output logic        Yin,
    output logic        ZLowIn,
    output logic        ZHighIn,
    output logic        Zlowout,
    output logic        ZHighout,
    output logic        LOin,
    output logic        HIin,
    output logic [15:0] Rin,
    output logic [15:0] Rout,
    output logic [4:0]  ALU_op,
    output logic        Busy,
    output logic        Done,
    output logic        Illegal,
    output logic        Bus_err
);

    localparam int CW = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        S_IDLE, S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6
    } state_t;

    state_t        state_q;
    logic [CW-1:0] wait_q;

    logic [4:0] opcode;
    logic [3:0] ra, rb, rc;
    logic       is_muldiv, legal, timeout;
    logic       unused_ir;

    assign opcode    = IR[31:27];
    assign ra        = IR[26:23];
    assign rb        = IR[22:19];
    assign rc        = IR[18:15];
    assign unused_ir = ^IR[14:0];

`ifdef MULDIV_EN
    assign is_muldiv = (opcode == 5'b01111) || (opcode == 5'b10000);
`else
    assign is_muldiv = 1'b0;
`endif
    assign legal   = ((opcode >= 5'b00011) && (opcode <= 5'b01010)) || is_muldiv;
    // This is the last T1 cycle that is allowed to go without an ack.
    // An ack in the same cycle still takes priority.
    assign timeout = (wait_q == CW'(TIMEOUT - 1));

    // State sequencing and the T1 wait counter, which restarts on each fetch
    always_ff @(posedge Clock or negedge Clear) begin
        if (!Clear) begin
            state_q <= S_IDLE;
            wait_q  <= '0;
        end else begin
            case (state_q)
                S_IDLE: if (Run) state_q <= S_T0;
                S_T0: begin
                    state_q <= S_T1;
                    wait_q  <= '0;
                end
                S_T1: begin
                    if (Mem_ack)                    state_q <= S_T2;
                    else if (timeout)               state_q <= S_IDLE;
                    else if (wait_q != CW'(TIMEOUT)) wait_q <= wait_q + CW'(1);
                end
                S_T2: state_q <= S_T3;
                S_T3: state_q <= legal ? S_T4 : S_IDLE;
                S_T4: state_q <= S_T5;
                S_T5: begin
                    if (is_muldiv) state_q <= S_T6;
                    else           state_q <= Run ? S_T0 : S_IDLE;
                end
`ifdef MULDIV_EN
                S_T6: state_q <= Run ? S_T0 : S_IDLE;
`endif
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Moore decode of the datapath controls. Only one bus driver is active per state.
    always_comb begin
        PCout    = 1'b0;
        MARin    = 1'b0;
        IncPC    = 1'b0;
        Read     = 1'b0;
        MDRin    = 1'b0;
        MDRout   = 1'b0;
        IRin     = 1'b0;
        Yin      = 1'b0;
        ZLowIn   = 1'b0;
        ZHighIn  = 1'b0;
        Zlowout  = 1'b0;
        ZHighout = 1'b0;
        LOin     = 1'b0;
        HIin     = 1'b0;
        Rin      = '0;
        Rout     = '0;
        ALU_op   = '0;
        Done     = 1'b0;
        Illegal  = 1'b0;
        Bus_err  = 1'b0;
        Busy     = (state_q != S_IDLE);
        case (state_q)
            S_T0: begin
                PCout = 1'b1;
                MARin = 1'b1;
                IncPC = 1'b1;
            end
            S_T1: begin
                Read    = 1'b1;
                MDRin   = 1'b1;
                Bus_err = timeout && !Mem_ack;
            end
            S_T2: begin
                MDRout = 1'b1;
                IRin   = 1'b1;
            end
            S_T3: begin
                if (legal) begin
                    Rout = 16'h0001 << rb;
                    Yin  = 1'b1;
                end else begin
                    Illegal = 1'b1;
                end
            end
            S_T4: begin
                Rout   = 16'h0001 << rc;
                ALU_op = opcode;
                ZLowIn = 1'b1;
`ifdef MULDIV_EN
                ZHighIn = is_muldiv;
`endif
            end
            S_T5: begin
                Zlowout = 1'b1;
                if (is_muldiv) begin
`ifdef MULDIV_EN
                    LOin = 1'b1;
`endif
                end else begin
                    Rin  = 16'h0001 << ra;
                    Done = 1'b1;
                end
            end
`ifdef MULDIV_EN
            S_T6: begin
                ZHighout = 1'b1;
                HIin     = 1'b1;
                Done     = 1'b1;
            end
`endif
            default: ;
        endcase
    end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Bench for alu_op_sequencer. A trace model expands each instruction into
// the output vectors it should produce, one vector per cycle, and places
// them in a queue. A memory model asserts Mem_ack after a chosen number of
// Read cycles. The compare process checks one queued vector against the DUT
// on every falling edge.
module tb_alu_op_sequencer;
    localparam int TIMEOUT = 15;
    localparam int NEVER   = 1000;

    logic        Clock = 1'b0, Clear = 1'b0, Run = 1'b0;
    logic [31:0] IR = '0;
    logic        Mem_ack;
    logic        PCout, MARin, IncPC, Read, MDRin, MDRout, IRin, Yin;
    logic        ZLowIn, ZHighIn, Zlowout, ZHighout, LOin, HIin;
    logic [15:0] Rin, Rout;
    logic [4:0]  ALU_op;
    logic        Busy, Done, Illegal, Bus_err;

    always #5 Clock = ~Clock;

    alu_op_sequencer #(.TIMEOUT(TIMEOUT)) dut (
        .Clock(Clock), .Clear(Clear), .Run(Run), .IR(IR), .Mem_ack(Mem_ack),
        .PCout(PCout), .MARin(MARin), .IncPC(IncPC), .Read(Read), .MDRin(MDRin),
        .MDRout(MDRout), .IRin(IRin), .Yin(Yin), .ZLowIn(ZLowIn), .ZHighIn(ZHighIn),
        .Zlowout(Zlowout), .ZHighout(ZHighout), .LOin(LOin), .HIin(HIin),
        .Rin(Rin), .Rout(Rout), .ALU_op(ALU_op), .Busy(Busy), .Done(Done),
        .Illegal(Illegal), .Bus_err(Bus_err)
    );

    typedef struct packed {
        logic pc, mar, inc, rd, mdrin, mdrout, irin, yin;
        logic zli, zhi, zlo, zho, loin, hiin, busy, done, ill, berr;
        logic [4:0]  op;
        logic [15:0] rin, rout;
    } ov_t;

    ov_t exp_q[$];
    int  checks = 0, failures = 0, cyc = 0;
    bit  mon_en = 1'b0;
    int  ack_dly = 0, rd_cnt = 0;

    // The memory acknowledges once Read has been high for ack_dly earlier cycles.
    always @(posedge Clock or negedge Clear)
        if (!Clear) rd_cnt <= 0;
        else        rd_cnt <= Read ? rd_cnt + 1 : 0;
    assign Mem_ack = Read && (rd_cnt >= ack_dly);

    always @(posedge Clock) cyc <= cyc + 1;

    function automatic ov_t actual();
        ov_t a;
        a.pc = PCout;     a.mar = MARin;   a.inc = IncPC;   a.rd = Read;
        a.mdrin = MDRin;  a.mdrout = MDRout; a.irin = IRin; a.yin = Yin;
        a.zli = ZLowIn;   a.zhi = ZHighIn; a.zlo = Zlowout; a.zho = ZHighout;
        a.loin = LOin;    a.hiin = HIin;   a.busy = Busy;   a.done = Done;
        a.ill = Illegal;  a.berr = Bus_err; a.op = ALU_op;
        a.rin = Rin;      a.rout = Rout;
        return a;
    endfunction

    task automatic chk(input string nm, input ov_t a, input ov_t e);
        checks++;
        if (a !== e) begin
            failures++;
            $display("FAIL %s got=%h want=%h", nm, a, e);
        end
    endtask

    task automatic chk_int(input string nm, input int a, input int e);
        checks++;
        if (a != e) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d", nm, a, e);
        end
    endtask

    // Compare process: one expected vector per cycle while the queue holds work.
    always @(negedge Clock) begin
        ov_t e;
        if (mon_en && exp_q.size() > 0) begin
            e = exp_q.pop_front();
            chk($sformatf("cyc%0d", cyc), actual(), e);
        end
    end

    // Trace model: the cycle-by-cycle outputs one instruction should produce.
    // dly is the number of T1 cycles that go by before memory acknowledges.
    task automatic push_instr(input logic [31:0] ir, input int dly, output int len);
        logic [4:0] opc;
        logic [3:0] ra, rb, rc;
        bit   md, lg, acked, timed;
        ov_t  o, b;
        opc = ir[31:27]; ra = ir[26:23]; rb = ir[22:19]; rc = ir[18:15];
`ifdef MULDIV_EN
        md = (opc == 5'd15) || (opc == 5'd16);
`else
        md = 1'b0;
`endif
        lg = (opc inside {[5'd3:5'd10]}) || md;
        b = '0; b.busy = 1'b1;
        len = 0; acked = 1'b0; timed = 1'b0;
        o = b; o.pc = 1; o.mar = 1; o.inc = 1; exp_q.push_back(o); len++;
        for (int i = 0; i < TIMEOUT && !acked && !timed; i++) begin
            o = b; o.rd = 1; o.mdrin = 1;
            if (i == dly) acked = 1'b1;
            else if (i == TIMEOUT - 1) begin o.berr = 1; timed = 1'b1; end
            exp_q.push_back(o); len++;
        end
        if (timed) return;
        o = b; o.mdrout = 1; o.irin = 1; exp_q.push_back(o); len++;
        o = b;
        if (!lg) begin
            o.ill = 1; exp_q.push_back(o); len++;
            return;
        end
        o.rout = 16'h0001 << rb; o.yin = 1; exp_q.push_back(o); len++;
        o = b; o.rout = 16'h0001 << rc; o.op = opc; o.zli = 1; o.zhi = md;
        exp_q.push_back(o); len++;
        o = b; o.zlo = 1;
        if (md) o.loin = 1;
        else begin o.rin = 16'h0001 << ra; o.done = 1; end
        exp_q.push_back(o); len++;
        if (md) begin
            o = b; o.zho = 1; o.hiin = 1; o.done = 1; exp_q.push_back(o); len++;
        end
    endtask

    // Wait for the compare process to empty the queue. A stuck queue counts as a failure.
    task automatic drain(input string nm);
        for (int c = 0; c < 300 && exp_q.size() > 0; c++) @(posedge Clock);
        checks++;
        if (exp_q.size() > 0) begin
            failures++;
            $display("FAIL %s_drain got=%0d want=0 entries left", nm, exp_q.size());
            exp_q.delete();
        end
    endtask

    // Run n copies of one instruction back to back. Run stays high until the
    // last instruction's T0, so every earlier Done is followed directly by T0.
    task automatic run_prog(input string nm, input logic [31:0] ir, input int dly, input int n);
        int k, len;
        ov_t z;
        z = '0;
        @(posedge Clock); #1;
        IR = ir; ack_dly = dly; Run = 1'b1;
        exp_q.push_back(z);
        k = 1;
        for (int j = 0; j < n; j++) begin
            push_instr(ir, dly, len);
            if (j < n - 1) k += len;
        end
        exp_q.push_back(z);
        repeat (k) @(posedge Clock);
        #1 Run = 1'b0;
        drain(nm);
    endtask

    initial begin
        int  len;
        ov_t z, t1;
        z = '0;
        t1 = '0; t1.busy = 1; t1.rd = 1; t1.mdrin = 1;

        // Check the model itself against hand-computed values.
        push_instr(32'h4A920000, 0, len);
        chk_int("model_and_len", len, 6);
        chk_int("model_and_t3_rout", int'(exp_q[3].rout), 16'h0004);
        chk_int("model_and_t4_rout", int'(exp_q[4].rout), 16'h0010);
        chk_int("model_and_t4_op", int'(exp_q[4].op), 5'b01001);
        chk_int("model_and_t5_rin", int'(exp_q[5].rin), 16'h0020);
        exp_q.delete();
        push_instr(32'h4A920000, 3, len);
        chk_int("model_wait_len", len, 9);
        exp_q.delete();
        push_instr(32'h4A920000, NEVER, len);
        chk_int("model_timeout_len", len, 1 + TIMEOUT);
        exp_q.delete();

        // Reset state
        #1 chk("reset_async", actual(), z);
        repeat (2) @(posedge Clock);
        #1 chk("reset_held", actual(), z);
        @(negedge Clock); #1 Clear = 1'b1;
        mon_en = 1'b1;

        run_prog("and_imm",   32'h4A920000, 0, 1);
        run_prog("and_wait3", 32'h4A920000, 3, 1);
        run_prog("sub_ack_at_timeout", {5'b00100, 4'd15, 4'd0, 4'd9, 15'd0}, TIMEOUT - 1, 1);
        run_prog("timeout",   32'h4A920000, NEVER, 1);
        run_prog("illegal",   32'hF8000000, 0, 1);
        run_prog("mul",       {5'b01111, 4'd1, 4'd2, 4'd3, 15'd0}, 1, 1);
        run_prog("div",       {5'b10000, 4'd4, 4'd5, 4'd6, 15'd0}, 0, 1);
        run_prog("op2_illegal", {5'b00010, 4'd1, 4'd1, 4'd1, 15'd0}, 0, 1);
        run_prog("add_b2b",   {5'b00011, 4'd0, 4'd15, 4'd7, 15'h1234}, 1, 2);
        run_prog("shr",       {5'b00101, 4'd3, 4'd8, 4'd14, 15'd0}, 2, 1);
        run_prog("rol",       {5'b01000, 4'd12, 4'd11, 4'd10, 15'd0}, 0, 1);
        run_prog("or_b2b",    {5'b01010, 4'd9, 4'd1, 4'd2, 15'd0}, 0, 2);

        // Reset in the middle of a T1 wait
        mon_en = 1'b0;
        @(posedge Clock); #1;
        IR = 32'h4A920000; ack_dly = NEVER; Run = 1'b1;
        repeat (3) @(posedge Clock);
        #1 chk("midT1_before_reset", actual(), t1);
        Clear = 1'b0;
        #1 chk("midT1_reset_async", actual(), z);
        @(negedge Clock); chk("midT1_reset_held", actual(), z);
        #1 Clear = 1'b1;
        mon_en = 1'b1;
        push_instr(32'h4A920000, NEVER, len);
        exp_q.push_back(z);
        @(posedge Clock); #1 Run = 1'b0;
        drain("after_reset");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=running want=finished");
        $fatal(1, "watchdog");
    end
endmodule
